mem_refill_responder: RTL

Main-memory side of the cache line-refill interface: accepts one line-refill request at a time from the direct-mapped cache's miss path. After a fixed access latency it returns the line as a burst of byte beats under valid/ready flow control. Data is a deterministic address pattern, so the bench can predict every beat without a backing array. The block sits between the cache controller's miss port and the simulation top level.

---
 rtl/cache_mem_pkg.sv | 20 ++
 rtl/mem_refill_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache refill path: geometry, responder FSM states
// and the deterministic line-data pattern used by both memory model and bench.
package cache_mem_pkg;

    localparam int ADDR_WIDTH   = 11;
    localparam int LINE_BYTES   = 16;
    localparam int OFFSET_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    // Byte stored at address a: low byte with the top address bits folded in.
    function automatic logic [7:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        return a[7:0] ^ {a[10:8], 5'b0};
    endfunction

endpackage

// File: rtl/mem_refill_responder.sv
// Main-memory side of the line-refill port: one request at a time, fixed
// access latency, then a byte-per-beat burst under valid/ready flow control.
module mem_refill_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = cache_mem_pkg::ADDR_WIDTH,
    parameter int LINE_BYTES = cache_mem_pkg::LINE_BYTES,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(LINE_BYTES)-1:0] rsp_offset,
    output logic                          rsp_last,
    output logic                          busy,
    output logic [15:0]                   req_count
);

    localparam int                 OFF_W     = $clog2(LINE_BYTES);
    localparam int                 LINE_W    = ADDR_WIDTH - OFF_W;
    localparam logic [OFF_W-1:0]   LAST_BEAT = OFF_W'(LINE_BYTES - 1);
    localparam logic [7:0]         LAT_INIT  = 8'(LATENCY);

    state_t                  r_state;
    logic [LINE_W-1:0]       r_line;
    logic [7:0]              r_lat_cnt;
    logic [OFF_W-1:0]        r_beat;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [OFF_W-1:0]        r_rsp_offset;
    logic                    r_rsp_last;
    logic                    r_busy;
    logic [15:0]             r_req_count;

    logic [LINE_W-1:0]       w_req_line;
    logic [OFF_W-1:0]        w_next_beat;
    logic [DATA_WIDTH-1:0]   w_req_first_data;
    logic [DATA_WIDTH-1:0]   w_line_first_data;
    logic [DATA_WIDTH-1:0]   w_next_data;
    logic [15:0]             w_count_inc;
    logic                    w_unused_offset;

    // The request's offset bits select nothing: a refill always starts at byte 0.
    assign w_unused_offset   = ^req_addr[OFF_W-1:0];
    assign w_req_line        = req_addr[ADDR_WIDTH-1:OFF_W];
    assign w_next_beat       = r_beat + OFF_W'(1);
    assign w_req_first_data  = DATA_WIDTH'(pattern({w_req_line, {OFF_W{1'b0}}}));
    assign w_line_first_data = DATA_WIDTH'(pattern({r_line, {OFF_W{1'b0}}}));
    assign w_next_data       = DATA_WIDTH'(pattern({r_line, w_next_beat}));
    assign w_count_inc       = (r_req_count == 16'hFFFF) ? r_req_count : r_req_count + 16'd1;

    // NOTE: reset is synchronous, so it lives inside the clocked branch; every
    // state register uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_lat_cnt    <= '0;
            r_beat       <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_offset <= '0;
            r_rsp_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_req_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_line      <= w_req_line;
                        r_lat_cnt   <= LAT_INIT;
                        r_beat      <= '0;
                        r_req_count <= w_count_inc;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (LATENCY == 0) begin
                            r_state      <= BURST;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_data   <= w_req_first_data;
                            r_rsp_offset <= '0;
                            r_rsp_last   <= (LAST_BEAT == '0);
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 8'd1;
                    // Outputs are registered, so the first beat is loaded one
                    // cycle before the counter would reach zero.
                    if (r_lat_cnt == 8'd1) begin
                        r_state      <= BURST;
                        r_beat       <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= w_line_first_data;
                        r_rsp_offset <= '0;
                        r_rsp_last   <= (LAST_BEAT == '0);
                    end
                end

                BURST: begin
                    if (rsp_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state      <= IDLE;
                            r_beat       <= '0;
                            r_req_ready  <= 1'b1;
                            r_rsp_valid  <= 1'b0;
                            r_rsp_data   <= '0;
                            r_rsp_offset <= '0;
                            r_rsp_last   <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_beat       <= w_next_beat;
                            r_rsp_data   <= w_next_data;
                            r_rsp_offset <= w_next_beat;
                            r_rsp_last   <= (w_next_beat == LAST_BEAT);
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_offset = r_rsp_offset;
    assign rsp_last   = r_rsp_last;
    assign busy       = r_busy;
    assign req_count  = r_req_count;

endmodule
